// File: rtl/scan_sequencer_4x16.sv
// scan_sequencer_4x16
//   Time-multiplexed channel scanner for a 4-to-16 decoder. It walks a 4-bit
//   channel index through the set bits of a 16-bit enable mask. Each channel
//   is held for dwell+1 cycles. The scan runs either one-shot or continuously.
//
//   Build option: SCAN_SEQ_BLANK_EN inserts one en=0 cycle between consecutive
//   channel windows, including at a wrap, so the decoder breaks before it makes.
//
// Parameters
//   DWELL_W : width of the dwell count (default 8)
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a scan; only looked at while idle
//   stop   in   abort a scan; also wins over a simultaneous start
//   cont   in   1 = wrap forever, 0 = one-shot; latched at start
//   mask   in   [15:0] channel enable mask, bit i = channel i
//   dwell  in   [DWELL_W-1:0] hold time minus one, in cycles
//   a      out  [3:0] registered channel index
//   en     out  registered decoder enable
//   busy   out  high while a scan is in progress
//   done   out  one-cycle pulse at the end of a one-shot scan
//                (also pulsed by a start with an empty mask)
module scan_sequencer_4x16 #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [15:0]        mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         a,
  output logic               en,
  output logic               busy,
  output logic               done
);

`ifdef SCAN_SEQ_BLANK_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  state_t             state, state_d;
  logic [15:0]        mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [3:0]         a_d;
  logic               en_d, busy_d, done_d;
  logic [15:0]        hi;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [3:0] lowest(input logic [15:0] m);
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) lowest = 4'(i);
  endfunction

  // Latched-mask channels strictly above the current one. When a is 15,
  // the shift wraps to zero and the mask below clears every bit.
  assign hi = mask_q & ~((16'd2 << a) - 16'd1);

  always_comb begin
    state_d = state;
    a_d     = a;
    en_d    = en;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = cnt;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (mask != 16'h0) begin
            mask_d  = mask;
            dwell_d = dwell;
            cont_d  = cont;
            a_d     = lowest(mask);
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt != dwell_q) begin
          cnt_d = cnt + 1'b1;
        end else begin
          cnt_d = '0;
          if (hi != 16'h0) begin
            a_d = lowest(hi);
`ifdef SCAN_SEQ_BLANK_EN
            state_d = BLANK;
            en_d    = 1'b0;
`endif
          end else if (cont_q && mask != 16'h0) begin
            // Frame wrap: the only point besides start where new mask and
            // dwell values are taken.
            mask_d  = mask;
            dwell_d = dwell;
            a_d     = lowest(mask);
`ifdef SCAN_SEQ_BLANK_EN
            state_d = BLANK;
            en_d    = 1'b0;
`endif
          end else begin
            // One-shot finish, or a wrap onto an empty mask, which ends
            // the scan like a stop (no done pulse).
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = !cont_q;
          end
        end
      end
`ifdef SCAN_SEQ_BLANK_EN
      BLANK: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ACTIVE;
          en_d    = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= 4'd0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      mask_q  <= 16'h0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
    end else begin
      state   <= state_d;
      a       <= a_d;
      en      <= en_d;
      busy    <= busy_d;
      done    <= done_d;
      cnt     <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
    end
  end

endmodule
